iq_feed_ctrl: RTL and testbench
===============================

Name: iq_feed_ctrl

Overview:
- Sequencer in front of the demodulator input stage.
- Pops a little-endian byte stream (I_lo, I_hi, Q_lo, Q_hi) from an upstream show-ahead byte FIFO.
- Assembles one signed I and one signed Q word per sample, then writes both into the real and imag input FIFOs in the same cycle, so the two demod channels stay in lockstep.
- Counts accepted samples and supports a sample-aligned enable.

Parameters:
- DATA_SIZE, 16, width of the assembled I/Q words; must equal 2*BYTE_SIZE.
- BYTE_SIZE, 8, width of the upstream byte FIFO.
- COUNT_WIDTH, 32, width of the sample counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled only in S_I0.
- in_dout  in  BYTE_SIZE  upstream FIFO head byte; valid while in_empty=0.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pops the upstream FIFO head this cycle.
- real_out  out  DATA_SIZE  assembled I word.
- real_wr_en  out  1  write strobe to the real FIFO.
- real_full  in  1  real FIFO full.
- imag_out  out  DATA_SIZE  assembled Q word.
- imag_wr_en  out  1  write strobe to the imag FIFO.
- imag_full  in  1  imag FIFO full.
- sample_count  out  COUNT_WIDTH  number of I/Q pairs written.
- busy  out  1  high in any state other than S_I0.

Behaviour:
- Reset, asynchronous: state=S_I0; real_out=0; imag_out=0; sample_count=0; in_rd_en=0, real_wr_en=0, imag_wr_en=0; busy=0.
- FSM states: S_I0, S_I1, S_Q0, S_Q1, S_WR.
- S_I0:
  - If enable=1 and in_empty=0: in_rd_en=1, i_lo<=in_dout, go to S_I1.
  - Otherwise hold, with in_rd_en=0.
- S_I1, S_Q0, S_Q1:
  - If in_empty=0: in_rd_en=1, capture byte, advance (S_I1 then S_Q0 then S_Q1 then S_WR).
  - Otherwise stall in place.
  - enable is ignored once S_I0 is left; a sample in progress always completes, so I/Q byte alignment is never broken.
- Word assembly:
  - real_out = {i_hi, i_lo} and imag_out = {q_hi, q_lo}, both registered.
  - real_out is updated when i_hi is captured; imag_out is updated when q_hi is captured.
  - Words are passed as raw two's-complement bits; no sign manipulation.
- S_WR:
  - If real_full=0 and imag_full=0: real_wr_en=1 and imag_wr_en=1 in the same cycle, sample_count<=sample_count+1, go to S_I0.
  - Otherwise stall with both strobes low.
  - The two strobes are never asserted independently.
- Strobes in_rd_en, real_wr_en and imag_wr_en are combinational from state and FIFO flags; there is no registered lag.
- Latency and throughput:
  - With no stalls, one sample takes 5 cycles, from the first pop to the write.
  - The write strobes go high in the cycle after the Q_hi pop.
- sample_count wraps modulo 2^COUNT_WIDTH, from max to 0, with no flag.
- At most one byte is popped per cycle; no pop occurs while in S_WR.
- Reset asserted mid-sample:
  - Partial bytes are discarded and the FSM returns to S_I0.
  - The upstream FIFO must be reset by the same signal so that byte alignment restarts cleanly.
- enable deasserted while in S_WR: the write still completes, then the FSM holds in S_I0.

Decomposition:
- Package fm_radio_pkg:
  - State enum iq_feed_state_t {S_I0, S_I1, S_Q0, S_Q1, S_WR}.
  - Constants BYTE_SIZE=8 and DATA_SIZE=16.
- No sub-module needed; this is a single FSM plus datapath registers.
- Instantiated alongside demodulate_top, driving its real/imag write ports.

Test Plan:
- Reset release, bytes 0x34,0x12,0x78,0x56 queued, enable=1:
  - 4 consecutive in_rd_en pulses.
  - Next cycle real_wr_en=imag_wr_en=1 with real_out=0x1234, imag_out=0x5678.
  - sample_count=1.
- Bytes 0x00,0x80,0xFF,0x7F: real_out=0x8000, imag_out=0x7FFF; both extremes pass through unchanged.
- in_empty forced to 1 after 2 bytes for 10 cycles:
  - FSM holds in S_Q0 with in_rd_en=0 and busy=1.
  - On resume, the pair is correct and no byte is skipped.
- imag_full=1 (real_full=0) while in S_WR for 6 cycles:
  - Neither strobe is asserted during the stall.
  - Both strobes assert together in the cycle after imag_full falls.
- enable dropped after the first byte of a sample:
  - That sample completes and is written.
  - No further pops occur while enable=0.
- Reset pulsed after 3 bytes, then 0x01,0x00,0x02,0x00 sent: real_out=0x0001, imag_out=0x0002, sample_count=1. Separately, with sample_count preloaded via force to 0xFFFFFFFF, one more write gives 0.

Source files
------------

// File: rtl/fm_radio_pkg.sv
// Shared types and constants for the FM radio receive path.
// The I/Q feed sequencer imports its state encoding and default word sizes from here.
package fm_radio_pkg;

  typedef enum logic [2:0] {
    S_I0,
    S_I1,
    S_Q0,
    S_Q1,
    S_WR
  } iq_feed_state_t;

  localparam int BYTE_SIZE = 8;
  localparam int DATA_SIZE = 16;

endpackage

// File: rtl/iq_feed_ctrl.sv
// Pulls little-endian I/Q byte quads from the upstream byte FIFO and writes each
// assembled sample into the real and imag demod FIFOs together, counting samples written.
module iq_feed_ctrl
  import fm_radio_pkg::*;
#(
  parameter int DATA_SIZE   = fm_radio_pkg::DATA_SIZE,
  parameter int BYTE_SIZE   = fm_radio_pkg::BYTE_SIZE,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [BYTE_SIZE-1:0]   in_dout,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  output logic [DATA_SIZE-1:0]   real_out,
  output logic                   real_wr_en,
  input  logic                   real_full,
  output logic [DATA_SIZE-1:0]   imag_out,
  output logic                   imag_wr_en,
  input  logic                   imag_full,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic                   busy
);

  iq_feed_state_t state, next_state;
  logic [BYTE_SIZE-1:0] i_lo, q_lo;
  logic                 write_pair;

  // Low bytes are parked until their high byte arrives, so each word only changes once complete.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_I0;
      i_lo         <= '0;
      q_lo         <= '0;
      real_out     <= '0;
      imag_out     <= '0;
      sample_count <= '0;
    end else begin
      state <= next_state;
      if (in_rd_en) begin
        case (state)
          S_I0:    i_lo     <= in_dout;
          S_I1:    real_out <= {in_dout, i_lo};
          S_Q0:    q_lo     <= in_dout;
          S_Q1:    imag_out <= {in_dout, q_lo};
          default: ;
        endcase
      end
      if (write_pair) sample_count <= sample_count + COUNT_WIDTH'(1);
    end
  end

  // enable only gates the start of a sample; once a quad has begun it always finishes.
  always_comb begin
    next_state = state;
    in_rd_en   = 1'b0;
    write_pair = 1'b0;
    if (!reset) begin
      case (state)
        S_I0: if (enable && !in_empty) begin
          in_rd_en   = 1'b1;
          next_state = S_I1;
        end
        S_I1: if (!in_empty) begin
          in_rd_en   = 1'b1;
          next_state = S_Q0;
        end
        S_Q0: if (!in_empty) begin
          in_rd_en   = 1'b1;
          next_state = S_Q1;
        end
        S_Q1: if (!in_empty) begin
          in_rd_en   = 1'b1;
          next_state = S_WR;
        end
        S_WR: if (!real_full && !imag_full) begin
          write_pair = 1'b1;
          next_state = S_I0;
        end
        default: next_state = S_I0;
      endcase
    end
  end

  // One shared strobe keeps the two demod channels in lockstep.
  assign real_wr_en = write_pair;
  assign imag_wr_en = write_pair;
  assign busy       = (state != S_I0);

endmodule

// File: tb/tb_iq_feed_ctrl.sv
// Scoreboard bench for iq_feed_ctrl: directed byte quads go into a modelled upstream FIFO,
// expected I/Q words are queued, and a monitor checks every write strobe against the queue.
module tb_iq_feed_ctrl;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [31:0] cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  in_dout = 8'h00;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [15:0] real_out;
  logic        real_wr_en;
  logic        real_full = 1'b0;
  logic [15:0] imag_out;
  logic        imag_wr_en;
  logic        imag_full = 1'b0;
  logic [31:0] sample_count;
  logic        busy;

  logic [7:0] byte_q[$];
  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         pop_count = 0;
  int         write_count = 0;

  iq_feed_ctrl dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .real_out(real_out), .real_wr_en(real_wr_en), .real_full(real_full),
    .imag_out(imag_out), .imag_wr_en(imag_wr_en), .imag_full(imag_full),
    .sample_count(sample_count), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic refreshFifo();
    in_empty = (byte_q.size() == 0);
    in_dout  = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
    byte_q.push_back(b0);
    byte_q.push_back(b1);
    byte_q.push_back(b2);
    byte_q.push_back(b3);
    refreshFifo();
  endtask

  task automatic expectPair(input logic [15:0] re, input logic [15:0] im, input logic [31:0] cnt);
    exp_t e;
    e.re = re;
    e.im = im;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic waitPops(input int target, input string name);
    int n = 0;
    while (pop_count < target && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (pop_count < target) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: pops=%0d, expected %0d within budget", name, pop_count, target);
    end
  endtask

  task automatic waitWrites(input int target, input string name);
    int n = 0;
    while (write_count < target && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (write_count < target) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: writes=%0d, expected %0d within budget", name, write_count, target);
    end
    @(posedge clock);
    #1;
  endtask

  // Upstream FIFO model: the head byte is consumed on every accepted pop.
  always @(posedge clock) begin
    if (in_rd_en && byte_q.size() != 0) begin
      void'(byte_q.pop_front());
      pop_count++;
    end
    #1 refreshFifo();
  end

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (real_wr_en || imag_wr_en) begin
      checkOutput("strobe_pair", {31'd0, real_wr_en}, {31'd0, imag_wr_en});
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: real_out=0x%0h, expected no write", real_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("real_out", {16'd0, real_out}, {16'd0, e.re});
        checkOutput("imag_out", {16'd0, imag_out}, {16'd0, e.im});
        checkOutput("count_at_write", sample_count, e.cnt);
      end
      write_count++;
    end
  end

  initial begin
    int base;
    @(negedge clock);
    checkOutput("reset_rd_en", {31'd0, in_rd_en}, 32'd0);
    checkOutput("reset_wr_en", {30'd0, real_wr_en, imag_wr_en}, 32'd0);
    checkOutput("reset_real", {16'd0, real_out}, 32'd0);
    checkOutput("reset_imag", {16'd0, imag_out}, 32'd0);
    checkOutput("reset_count", sample_count, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic sample: four back-to-back pops, then the paired write.
    expectPair(16'h1234, 16'h5678, 32'd0);
    applyStimulus(8'h34, 8'h12, 8'h78, 8'h56);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("pop_%0d", i), {31'd0, in_rd_en}, 32'd1);
    end
    @(negedge clock);
    checkOutput("write_after_pops", {30'd0, real_wr_en, imag_wr_en}, 32'd3);
    waitWrites(1, "basic_write");
    checkOutput("count_one", sample_count, 32'd1);

    // Signed extremes pass through as raw bits.
    expectPair(16'h8000, 16'h7FFF, 32'd1);
    applyStimulus(8'h00, 8'h80, 8'hFF, 8'h7F);
    waitWrites(2, "extreme_write");

    // Upstream runs dry after two bytes: the FSM must park in S_Q0.
    expectPair(16'hDABC, 16'h0DF0, 32'd2);
    base = pop_count;
    byte_q.push_back(8'hBC);
    byte_q.push_back(8'hDA);
    refreshFifo();
    waitPops(base + 2, "stall_prefix");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("stall_rd_en", {31'd0, in_rd_en}, 32'd0);
      checkOutput("stall_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clock);
    #1;
    byte_q.push_back(8'hF0);
    byte_q.push_back(8'h0D);
    refreshFifo();
    waitWrites(3, "stall_resume");

    // imag FIFO full while the pair is ready: nothing may be written.
    expectPair(16'h2143, 16'h6587, 32'd3);
    imag_full = 1'b1;
    base = pop_count;
    applyStimulus(8'h43, 8'h21, 8'h87, 8'h65);
    waitPops(base + 4, "full_pops");
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checkOutput("full_hold", {30'd0, real_wr_en, imag_wr_en}, 32'd0);
      checkOutput("full_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clock);
    #1 imag_full = 1'b0;
    @(negedge clock);
    checkOutput("full_release", {30'd0, real_wr_en, imag_wr_en}, 32'd3);
    waitWrites(4, "full_write");

    // Dropping enable mid-sample finishes that sample and starts no other.
    expectPair(16'h2211, 16'h4433, 32'd4);
    base = pop_count;
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(8'h55, 8'h66, 8'h77, 8'h88);
    waitPops(base + 1, "enable_first_pop");
    enable = 1'b0;
    waitWrites(5, "enable_drop_write");
    repeat (20) @(negedge clock);
    checkOutput("enable_drop_pops", pop_count, base + 4);
    checkOutput("enable_drop_left", byte_q.size(), 32'd4);
    checkOutput("enable_drop_busy", {31'd0, busy}, 32'd0);
    checkOutput("count_five", sample_count, 32'd5);

    // Reset after three bytes discards the partial sample; upstream is flushed too.
    byte_q.delete();
    refreshFifo();
    enable = 1'b1;
    base = pop_count;
    applyStimulus(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    waitPops(base + 3, "reset_prefix");
    reset = 1'b1;
    byte_q.delete();
    refreshFifo();
    #1;
    checkOutput("midreset_count", sample_count, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_rd_en", {31'd0, in_rd_en}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    expectPair(16'h0001, 16'h0002, 32'd0);
    applyStimulus(8'h01, 8'h00, 8'h02, 8'h00);
    waitWrites(6, "post_reset_write");
    checkOutput("post_reset_count", sample_count, 32'd1);

    // Counter wraps from all-ones to zero.
    @(negedge clock);
    force dut.sample_count = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.sample_count;
    expectPair(16'h0005, 16'h0006, 32'hFFFF_FFFF);
    applyStimulus(8'h05, 8'h00, 8'h06, 8'h00);
    waitWrites(7, "wrap_write");
    checkOutput("wrap_count", sample_count, 32'd0);

    repeat (3) @(negedge clock);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
